// File: rtl/lte_dl_iq_clip_if.sv
// lte_dl_iq_clip_if
// Sample stream bundle for the downlink IQ path: one 32-bit IQ sample per
// clock with its radio-frame header and antenna-0 slot marker.
//   fram_hd : radio-frame header pulse, aligned with the first frame sample
//   xant_hd : antenna-0 slot marker of each antenna group
//   data    : I[31:16], Q[15:0], two's complement
// The master modport drives the stream, the slave modport receives it.
interface lte_dl_iq_clip_if;
  logic        fram_hd;
  logic        xant_hd;
  logic [31:0] data;

  modport master (output fram_hd, output xant_hd, output data);
  modport slave  (input  fram_hd, input  xant_hd, input  data);
endinterface

// File: rtl/lte_dl_iq_clip.sv
// lte_dl_iq_clip
// Per-antenna digital IQ clipper for the LTE downlink path (between the
// downlink AGC and the downlink delay stage). I and Q are hard-limited to a
// symmetric threshold, clipped samples are counted per antenna over each
// radio frame, and antenna-slot alignment of the TDM stream is checked.
// Ports:
//   clk, asy_rst  : system clock, asynchronous active-high reset
//   s_in          : input sample stream (fram_hd, xant_hd, data)
//   m_out         : output sample stream, 2-cycle fixed latency
//   i_clip_en     : 1 = clip and count, 0 = bit-exact pass-through
//   i_clip_thr    : clip threshold magnitude, taken at each frame header
//   i_err_clr     : clears o_align_err
//   i_cnt_raddr   : antenna index for the clip-count read
//   o_cnt_rdata   : previous-frame clip count of antenna i_cnt_raddr
//   o_align_err   : sticky antenna-misalignment flag
module lte_dl_iq_clip #(
  parameter int XNUM  = 8,
  parameter int CNT_W = 24
) (
  input  logic                clk,
  input  logic                asy_rst,
  lte_dl_iq_clip_if.slave     s_in,
  lte_dl_iq_clip_if.master    m_out,
  input  logic                i_clip_en,
  input  logic [15:0]         i_clip_thr,
  input  logic                i_err_clr,
  input  logic [2:0]          i_cnt_raddr,
  output logic [CNT_W-1:0]    o_cnt_rdata,
  output logic                o_align_err
);

  localparam int               IDX_W    = (XNUM > 1) ? $clog2(XNUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XNUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      THR_MAX  = 16'h7FFF;
  localparam logic [15:0]      THR_RST  = 16'h7FFF;

  // Stage-1 registers
  logic [31:0]      s1_data_q, s1_data_d;
  logic             s1_fram_q, s1_fram_d;
  logic             s1_xant_q, s1_xant_d;
  logic             s1_en_q, s1_en_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             synced_q, synced_d;
  logic             misalign_q, misalign_d;
  logic [15:0]      thr_q, thr_d;

  // Stage-2 registers
  logic [31:0]      out_data_q, out_data_d;
  logic             out_fram_q, out_fram_d;
  logic             out_xant_q, out_xant_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0] live_q [XNUM];
  logic [CNT_W-1:0] live_d [XNUM];
  logic [CNT_W-1:0] report_q [XNUM];
  logic [CNT_W-1:0] report_d [XNUM];

  logic [16:0] i_res;
  logic [16:0] q_res;
  logic        hit;
  logic        cnt_hit;

  // Symmetric hard limit of one 16-bit component; bit 16 flags a clip.
  // thr never exceeds 32767, so -thr is always representable.
  function automatic logic [16:0] clip16(input logic [15:0] x, input logic [15:0] thr);
    logic signed [16:0] xs;
    logic signed [16:0] ts;
    logic [16:0]        res;
    xs = {x[15], x};
    ts = {1'b0, thr};
    if (xs > ts) begin
      res = {1'b1, thr};
    end else if (xs < -ts) begin
      res = {1'b1, ~thr + 16'd1};
    end else begin
      res = {1'b0, x};
    end
    return res;
  endfunction

  // Stage 1: capture the sample, track the antenna slot, detect an early
  // antenna-0 marker, and shadow the threshold at the frame header so the
  // header sample and the rest of its frame see the same threshold.
  always_comb begin
    s1_data_d  = s_in.data;
    s1_fram_d  = s_in.fram_hd;
    s1_xant_d  = s_in.xant_hd;
    s1_en_d    = i_clip_en;
    synced_d   = synced_q;
    misalign_d = s_in.xant_hd && synced_q && (idx_q != IDX_LAST);
    if (s_in.xant_hd) begin
      idx_d    = '0;
      synced_d = 1'b1;
    end else if (idx_q == IDX_LAST) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + 1'b1;
    end
    thr_d = thr_q;
    if (s_in.fram_hd) begin
      thr_d = (i_clip_thr > THR_MAX) ? THR_MAX : i_clip_thr;
    end
  end

  // Stage 2: clip I and Q independently; a sample with either component
  // clipped is one hit. Disabled clipping passes the sample through intact.
  always_comb begin
    i_res      = clip16(s1_data_q[31:16], thr_q);
    q_res      = clip16(s1_data_q[15:0], thr_q);
    out_fram_d = s1_fram_q;
    out_xant_d = s1_xant_q;
    if (s1_en_q) begin
      out_data_d = {i_res[15:0], q_res[15:0]};
      hit        = i_res[16] | q_res[16];
    end else begin
      out_data_d = s1_data_q;
      hit        = 1'b0;
    end
    cnt_hit = hit && synced_q;
  end

  // Per-antenna counters. At the header sample the live counts move to the
  // report bank and restart; the header sample itself opens the new frame.
  always_comb begin
    live_d   = live_q;
    report_d = report_q;
    for (int k = 0; k < XNUM; k++) begin
      if (s1_fram_q) begin
        report_d[k] = live_q[k];
        live_d[k]   = (cnt_hit && (idx_q == IDX_W'(k))) ? CNT_ONE : '0;
      end else if (cnt_hit && (idx_q == IDX_W'(k)) && (live_q[k] != CNT_MAX)) begin
        live_d[k] = live_q[k] + CNT_ONE;
      end
    end
  end

  // Sticky misalignment flag aligned with the offending sample's output;
  // a new misalignment beats a simultaneous clear.
  always_comb begin
    err_d = misalign_q | (err_q & ~i_err_clr);
  end

  // Registered report read; addresses beyond the antenna count read 0.
  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < XNUM; k++) begin
      if (int'(i_cnt_raddr) == k) begin
        rdata_d = report_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      s1_data_q  <= '0;
      s1_fram_q  <= 1'b0;
      s1_xant_q  <= 1'b0;
      s1_en_q    <= 1'b0;
      idx_q      <= '0;
      synced_q   <= 1'b0;
      misalign_q <= 1'b0;
      thr_q      <= THR_RST;
      out_data_q <= '0;
      out_fram_q <= 1'b0;
      out_xant_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      for (int k = 0; k < XNUM; k++) begin
        live_q[k]   <= '0;
        report_q[k] <= '0;
      end
    end else begin
      s1_data_q  <= s1_data_d;
      s1_fram_q  <= s1_fram_d;
      s1_xant_q  <= s1_xant_d;
      s1_en_q    <= s1_en_d;
      idx_q      <= idx_d;
      synced_q   <= synced_d;
      misalign_q <= misalign_d;
      thr_q      <= thr_d;
      out_data_q <= out_data_d;
      out_fram_q <= out_fram_d;
      out_xant_q <= out_xant_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      for (int k = 0; k < XNUM; k++) begin
        live_q[k]   <= live_d[k];
        report_q[k] <= report_d[k];
      end
    end
  end

  assign m_out.data    = out_data_q;
  assign m_out.fram_hd = out_fram_q;
  assign m_out.xant_hd = out_xant_q;
  assign o_cnt_rdata   = rdata_q;
  assign o_align_err   = err_q;

endmodule

// File: doc/lte_dl_iq_clip.md
Name: lte_dl_iq_clip

Overview:
- Per-antenna digital IQ clipper for the LTE downlink path. Sits directly downstream of the downlink AGC stage and directly upstream of the downlink delay stage.
- Hard-limits each I and Q sample to a programmable symmetric threshold.
- Counts clipped samples per antenna over each radio frame and exposes the latched counts through a register read port.
- Checks antenna-slot alignment of the TDM stream and flags any misalignment.

Parameters:
- XNUM, 8, number of antennas time-multiplexed on the stream.
- CNT_W, 24, width of the per-antenna clip counters (saturating).

Ports:
- clk  in  1  245.76 MHz system clock.
- asy_rst  in  1  reset; asynchronous, active-high.
- i_fram_hd  in  1  radio-frame header pulse, aligned with the first sample of the frame.
- i_xant_hd  in  1  antenna-0 slot marker; asserted on the antenna-0 sample of each XNUM-sample group.
- i_data  in  32  sample: I[31:16], Q[15:0], two's complement.
- i_clip_en  in  1  1 = clip and count; 0 = pass-through, no counting.
- i_clip_thr  in  16  clip threshold magnitude, unsigned.
- i_err_clr  in  1  clears o_align_err.
- i_cnt_raddr  in  3  antenna index for the clip-count read.
- o_cnt_rdata  out  CNT_W  latched clip count of the previous frame for antenna i_cnt_raddr.
- o_fram_hd  out  1  i_fram_hd delayed by 2 cycles.
- o_xant_hd  out  1  i_xant_hd delayed by 2 cycles.
- o_data  out  32  clipped sample, same format as i_data.
- o_align_err  out  1  sticky antenna-misalignment flag.

Behaviour:
- Reset values: all outputs 0. Antenna index = 0; synced flag = 0; live and report counters = 0; threshold shadow = 16'h7FFF.
- Latency: fixed 2 cycles on data, fram_hd and xant_hd. No stalls, no valid signal; one sample per clk.
- Stage 1: registers i_data, i_fram_hd, i_xant_hd and assigns the antenna index.
  - i_xant_hd = 1: idx = 0, synced = 1.
  - Otherwise: idx = idx + 1, wrapping XNUM-1 -> 0.
- Misalignment: i_xant_hd = 1 while synced = 1 and the previous idx != XNUM-1 sets o_align_err. The index still resyncs to 0.
- o_align_err clears on i_err_clr. If set and clear occur in the same cycle, set wins.
- Threshold shadow: loads min(i_clip_thr, 32767) on every cycle where i_fram_hd = 1. Mid-frame threshold writes take effect at the next frame header.
- Stage 2 clip, applied to I and Q independently with thr = shadow value:
  - x > thr -> thr.
  - x < -thr -> -thr.
  - Otherwise x unchanged.
  - Example: -32768 with thr 32767 outputs -32767 (0x8001). thr = 0 forces all samples to 0.
- hit = I clipped OR Q clipped. A sample counts at most once.
- Counting runs only when i_clip_en = 1 and synced = 1. Each hit increments live[idx], saturating at 2^CNT_W - 1.
- With i_clip_en = 0, o_data equals i_data exactly (2-cycle delay) and nothing is counted.
- Frame boundary is the stage-2 cycle whose delayed fram_hd = 1:
  - report[k] <= live[k] for every k.
  - live[k] <= 1 if k == idx and hit, else 0. The header sample belongs to the new frame.
- Before the first i_xant_hd after reset (synced = 0), samples are still clipped but not counted.
- Read port: o_cnt_rdata <= report[i_cnt_raddr], registered, 1-cycle read latency. Addresses >= XNUM return 0.
- Reset mid-frame: everything returns to reset values immediately. The next frame header latches whatever was counted since reset.

Test Plan:
- Pass-through: i_clip_en = 0, random data with xant every 8 cycles -> o_data equals i_data delayed 2 cycles bit-exact; all counts read 0 after a frame header.
- Clipping: thr = 1000, enabled, i_data = {16'd1500, -16'd2000} -> o_data = {16'd1000, -16'd1000}. An antenna-3 slot clipping in 5 groups gives report[3] = 5 after the next header; other antennas read 0.
- Threshold limits: thr = 16'hFFFF (used as 32767), I = 0x8000 -> 0x8001. thr = 0 -> o_data = 0 for all samples.
- Threshold timing: write thr = 500 mid-frame -> old threshold holds until the next i_fram_hd, then 600 clips to 500.
- Alignment: i_xant_hd arrives after 5 samples instead of 8 -> o_align_err = 1 two cycles later. Index restarts at 0. i_err_clr -> 0. Set and clear in the same cycle -> stays 1.
- Boundary and saturation: clip on the header sample of antenna 0 -> new live[0] = 1, and that sample is not in report[0]. With CNT_W = 4 build, 20 hits -> report reads 15. Read of raddr 7 returns report[7] one cycle after the address is applied.
